// File: rtl/multdiv_sequencer_if.sv
// rtl/multdiv_sequencer_if.sv - control/datapath bundle for the multdiv sequencer
interface multdiv_sequencer_if #(
    parameter int CW = 6
);
    logic          ctrl_MULT;
    logic          ctrl_DIV;
    logic          divisor_zero;
    logic          load_operands;
    logic          step_mult;
    logic          step_div;
    logic          op_is_div;
    logic          busy;
    logic          data_resultRDY;
    logic          data_exception;
    logic [CW-1:0] step_count;

    modport master (
        output ctrl_MULT, ctrl_DIV, divisor_zero,
        input  load_operands, step_mult, step_div, op_is_div, busy,
               data_resultRDY, data_exception, step_count
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, divisor_zero,
        output load_operands, step_mult, step_div, op_is_div, busy,
               data_resultRDY, data_exception, step_count
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - IDLE/LOAD/RUN/DONE sequencer for the iterative multiply/divide datapath
module multdiv_sequencer #(
    parameter int STEPS = 32,
    parameter int CW    = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_sequencer_if.slave   io
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_is_div_q, op_is_div_d;
    logic          exc_q, exc_d;
    logic          load_q, load_d;
    logic          step_mult_q, step_mult_d;
    logic          step_div_q, step_div_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;
    logic          exc_out_q, exc_out_d;
    logic          start;

    assign start = io.ctrl_MULT | io.ctrl_DIV;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_is_div_d = op_is_div_q;
        exc_d       = exc_q;
        if (start) begin
            // Any start, in any state, aborts whatever is running.
            state_d     = S_LOAD;
            cnt_d       = '0;
            op_is_div_d = io.ctrl_DIV & ~io.ctrl_MULT;
            exc_d       = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: begin
                    if (op_is_div_q && io.divisor_zero) begin
                        state_d = S_DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(STEPS - 1)) state_d = S_DONE;
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Strobes are decoded from the next state so they leave the flops aligned with it.
        load_d      = (state_d == S_LOAD);
        step_mult_d = (state_d == S_RUN) && !op_is_div_d;
        step_div_d  = (state_d == S_RUN) &&  op_is_div_d;
        busy_d      = (state_d == S_LOAD) || (state_d == S_RUN);
        rdy_d       = (state_d == S_DONE);
        exc_out_d   = (state_d == S_DONE) && exc_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_is_div_q <= 1'b0;
            exc_q       <= 1'b0;
            load_q      <= 1'b0;
            step_mult_q <= 1'b0;
            step_div_q  <= 1'b0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b0;
            exc_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_is_div_q <= op_is_div_d;
            exc_q       <= exc_d;
            load_q      <= load_d;
            step_mult_q <= step_mult_d;
            step_div_q  <= step_div_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
            exc_out_q   <= exc_out_d;
        end
    end

    assign io.load_operands  = load_q;
    assign io.step_mult      = step_mult_q;
    assign io.step_div       = step_div_q;
    assign io.op_is_div      = op_is_div_q;
    assign io.busy           = busy_q;
    assign io.data_resultRDY = rdy_q;
    assign io.data_exception = exc_out_q;
    assign io.step_count     = cnt_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - randomized self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;
    localparam int STEPS = 32;
    localparam int CW    = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: age in cycles since the latest start pulse
    bit   m_active = 0;
    int   m_age    = 0;
    bit   m_div    = 0;
    bit   m_zero   = 0;

    multdiv_sequencer_if #(.CW(CW)) bus ();

    multdiv_sequencer #(.STEPS(STEPS), .CW(CW)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_age    = 0;
        m_div    = 0;
        m_zero   = 0;
    endtask

    task automatic check_all();
        logic ld, sm, sd, bz, rdy, exc;
        int   cnt;
        ld = 0; sm = 0; sd = 0; bz = 0; rdy = 0; exc = 0; cnt = 0;
        if (m_active) begin
            if (m_age == 1) begin
                ld = 1; bz = 1; cnt = 0;
            end else if (m_div && m_zero) begin
                rdy = (m_age == 2);
                exc = (m_age == 2);
                cnt = 0;
            end else if (m_age <= STEPS + 1) begin
                bz = 1; sm = !m_div; sd = m_div; cnt = m_age - 2;
            end else begin
                rdy = (m_age == STEPS + 2);
                cnt = STEPS;
            end
        end
        check_eq("load_operands",  32'(bus.load_operands),  32'(ld));
        check_eq("step_mult",      32'(bus.step_mult),      32'(sm));
        check_eq("step_div",       32'(bus.step_div),       32'(sd));
        check_eq("busy",           32'(bus.busy),           32'(bz));
        check_eq("data_resultRDY", 32'(bus.data_resultRDY), 32'(rdy));
        check_eq("data_exception", 32'(bus.data_exception), 32'(exc));
        check_eq("op_is_div",      32'(bus.op_is_div),      32'(m_div));
        check_eq("step_count",     32'(bus.step_count),     32'(cnt));
    endtask

    task automatic tick(input bit mult, input bit div, input bit dz);
        bus.ctrl_MULT    = mult;
        bus.ctrl_DIV     = div;
        bus.divisor_zero = dz;
        @(negedge clock);
        check_all();
        @(posedge clock);
        cyc++;
        if (mult || div) begin
            m_active = 1;
            m_age    = 1;
            m_div    = div && !mult;
            m_zero   = 0;
        end else if (m_active) begin
            if (m_age == 1) m_zero = dz;
            if (m_age < 1000) m_age++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    task automatic async_reset();
        bus.ctrl_MULT = 0;
        bus.ctrl_DIV  = 0;
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        cyc++;
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        bus.ctrl_MULT    = 0;
        bus.ctrl_DIV     = 0;
        bus.divisor_zero = 0;
        #2;
        check_all();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(3);

        // Plain multiply
        tick(1, 0, 0);
        idle(37);

        // Divide by zero
        tick(0, 1, 0);
        tick(0, 0, 1);
        idle(4);

        // Divide aborted by multiply in cycle 10
        tick(0, 1, 0);
        idle(9);
        tick(1, 0, 0);
        idle(37);

        // Simultaneous start (divisor_zero ignored), then divide issued in DONE
        tick(1, 1, 0);
        tick(0, 0, 1);
        idle(32);
        tick(0, 1, 0);
        idle(37);

        // Async reset mid-run at step_count 17, then a fresh multiply
        tick(1, 0, 0);
        idle(18);
        async_reset();
        idle(2);
        tick(1, 0, 0);
        idle(37);

        // Zero-divisor flag present during a normal divide's RUN must not matter
        tick(0, 1, 0);
        tick(0, 0, 0);
        for (int i = 0; i < 34; i++) tick(0, 0, 1'($urandom_range(0, 1)));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit s, m, d;
            s = ($urandom_range(0, 19) == 0);
            m = s && ($urandom_range(0, 2) != 0);
            d = s && (!m || ($urandom_range(0, 3) == 0));
            tick(m, d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Cycle sequencer for the processor's iterative multiply/divide unit. It accepts one-cycle multiply or divide start pulses and owns the step counter, built the same way as the existing 5/6-bit adder-register counters. It issues load and per-step enables to the shift/add datapath, then flags result-ready or divide-by-zero. It sits between the execute-stage control decode and the multdiv datapath.

## Interface
- STEPS, 32, datapath iterations per operation, 1..(2^CW − 1)
- CW, 6, step counter width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE immediately
- ctrl_MULT  in  1  start multiply, single-cycle pulse
- ctrl_DIV  in  1  start divide, single-cycle pulse
- divisor_zero  in  1  datapath flag, divisor operand == 0, valid during LOAD
- load_operands  out  1  datapath latches operands, clears accumulator
- step_mult  out  1  perform one multiply iteration this cycle
- step_div  out  1  perform one divide iteration this cycle
- op_is_div  out  1  current/last operation is a divide
- busy  out  1  operation in progress (LOAD or RUN)
- data_resultRDY  out  1  result valid this cycle
- data_exception  out  1  divide by zero; qualified by data_resultRDY
- step_count  out  CW  completed iterations of the current operation

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are decoded from the state register, op_is_div, and step_count. No input-to-output combinational paths.
- Reset values: state IDLE; step_count 0; op_is_div 0; all other outputs 0.
- Start: a pulse on ctrl_MULT or ctrl_DIV is sampled in any state and moves to LOAD next cycle.
  - On a start, op_is_div is set to ctrl_DIV & ~ctrl_MULT and step_count clears to 0.
  - Both pulses high in the same cycle: treated as a multiply.
  - A start during LOAD or RUN aborts the current operation with no resultRDY and restarts.
  - A start during DONE is accepted; the current DONE cycle still shows resultRDY for the previous operation.
- LOAD (1 cycle): load_operands=1, busy=1.
  - op_is_div=1 and divisor_zero=1 → DONE with the exception latched.
  - Otherwise → RUN.
  - divisor_zero is ignored for multiplies.
- RUN: busy=1. Each cycle, exactly one of step_mult/step_div is 1 (per op_is_div), and step_count increments by 1 at the clock edge.
  - With step_count == STEPS−1 in a RUN cycle, the next state is DONE and step_count becomes STEPS.
- DONE (1 cycle): data_resultRDY=1, busy=0, data_exception=latched flag. With no new start, → IDLE.
- IDLE: all strobes 0. step_count and op_is_div hold their last values.
- Counter arithmetic: unsigned CW-bit, +1 only in RUN, never wraps because STEPS < 2^CW.
- The exception flag clears on every start and on reset.

## Timing
- Start pulse in cycle 0 → LOAD in cycle 1 → RUN in cycles 2..STEPS+1 (step_count 0..STEPS−1 during those cycles) → DONE in cycle STEPS+2 → IDLE in cycle STEPS+3.
- Normal latency: pulse to data_resultRDY is STEPS+2 cycles (34 for the default).
- Divide by zero: pulse in cycle 0 → LOAD in cycle 1 → DONE in cycle 2, with resultRDY=1 and exception=1.
- Exactly STEPS step strobes per completed operation. An aborted operation produces no resultRDY.
- Asynchronous reset mid-operation: outputs drop to reset values without waiting for a clock edge. The first start after reset deassertion behaves as from IDLE.
- data_resultRDY is high for exactly one cycle per completed operation.

## Test plan
- Reset: assert reset mid-cycle with no clock edge → all outputs 0 and step_count=0 immediately. Release, no starts → outputs stay 0.
- Multiply, STEPS=32: ctrl_MULT pulse in cycle 0 → load_operands in cycle 1, step_mult in cycles 2–33 (32 pulses), data_resultRDY in cycle 34 only, exception=0, step_count=32 afterward, busy in cycles 1–33.
- Divide by zero: ctrl_DIV pulse with divisor_zero=1 during LOAD → resultRDY=1 and exception=1 in cycle 2, no step_div pulses, op_is_div=1.
- Restart: ctrl_DIV pulse, then ctrl_MULT pulse in cycle 10 (RUN) → no resultRDY for the divide, LOAD in cycle 11, 32 step_mult pulses, resultRDY in cycle 44, op_is_div=0.
- Simultaneous and back-to-back: ctrl_MULT and ctrl_DIV high together → multiply. A new ctrl_DIV pulse in the DONE cycle → resultRDY still 1 that cycle, LOAD in the next cycle, divide completes normally.
- Async reset in RUN at step_count=17 → immediate IDLE, no resultRDY. A later ctrl_MULT completes in 34 cycles.
